// File: rtl/cache_access_sequencer.sv
// ============================================================================
// Module   : cache_access_sequencer
// Purpose  : Processor-side requester that queues load/store requests, drives
//            them one at a time into the set-associative cache and returns
//            in-order responses, with flush sequencing and a stall watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_access_sequencer #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_PTR_BITS  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic                      resp_valid,
  output logic                      resp_wr,
  output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
  output logic                      resp_err,
  output logic                      err_sticky,
  output logic [ADDR_BUS_WIDTH-1:0] addr,
  output logic [DATA_BUS_WIDTH-1:0] wdata,
  output logic                      rd,
  output logic                      wr,
  output logic                      flush,
  input  logic                      stall,
  input  logic [DATA_BUS_WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam logic [FIFO_PTR_BITS:0] c_FIFO_FULL = (FIFO_PTR_BITS+1)'(FIFO_DEPTH);
  localparam logic [7:0]             c_WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                    r_state;
  logic                      r_fifo_wr    [FIFO_DEPTH];
  logic [ADDR_BUS_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic [DATA_BUS_WIDTH-1:0] r_fifo_wdata [FIFO_DEPTH];
  logic [FIFO_PTR_BITS-1:0]  r_wptr;
  logic [FIFO_PTR_BITS-1:0]  r_rptr;
  logic [FIFO_PTR_BITS:0]    r_count;
  logic                      r_flush_pend;
  logic [7:0]                r_wdog;

  logic                      r_flush_done;
  logic                      r_resp_valid;
  logic                      r_resp_wr;
  logic [DATA_BUS_WIDTH-1:0] r_resp_rdata;
  logic                      r_resp_err;
  logic                      r_err_sticky;
  logic [ADDR_BUS_WIDTH-1:0] r_addr;
  logic [DATA_BUS_WIDTH-1:0] r_wdata;
  logic                      r_rd;
  logic                      r_wr;
  logic                      r_flush;

  logic w_ready;
  logic w_push;
  logic w_expire;
  logic w_pop;
  logic w_fifo_empty;

  // Full is judged on the current count only, so a same-cycle pop never
  // lets a push through.
  assign w_ready      = (r_count != c_FIFO_FULL) && !r_flush_pend;
  assign w_push       = req_valid && w_ready;
  assign w_expire     = stall && (r_wdog == c_WDOG_LAST);
  assign w_pop        = (r_state == ST_ACCESS) && (!stall || w_expire);
  assign w_fifo_empty = (r_count == '0);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_wr[r_wptr]    <= req_wr;
      r_fifo_addr[r_wptr]  <= req_addr;
      r_fifo_wdata[r_wptr] <= req_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_flush_pend <= 1'b0;
      r_wdog       <= '0;
      r_flush_done <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_wr    <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_resp_valid <= 1'b0;
      r_resp_wr    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_flush_done <= 1'b0;
      if (flush_req) r_flush_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_wdog <= '0;
          // Queued requests go first so a flush is ordered after all of them.
          if (!w_fifo_empty) begin
            r_addr  <= r_fifo_addr[r_rptr];
            r_wdata <= r_fifo_wdata[r_rptr];
            r_rd    <= !r_fifo_wr[r_rptr];
            r_wr    <= r_fifo_wr[r_rptr];
            r_state <= ST_ACCESS;
          end else if (r_flush_pend) begin
            r_flush <= 1'b1;
            r_state <= ST_FLUSH;
          end
        end
        ST_ACCESS: begin
          if (!stall || w_expire) begin
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_wr    <= r_wr;
            r_resp_err   <= stall;
            r_resp_rdata <= (r_wr || stall) ? '0 : rdata;
            if (stall) r_err_sticky <= 1'b1;
            r_wdog       <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (!stall || w_expire) begin
            r_flush      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_flush_done <= 1'b1;
            if (stall) r_err_sticky <= 1'b1;
            r_wdog       <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: begin
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_flush <= 1'b0;
          r_wdog  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = w_ready;
  assign flush_done = r_flush_done;
  assign resp_valid = r_resp_valid;
  assign resp_wr    = r_resp_wr;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign err_sticky = r_err_sticky;
  assign addr       = r_addr;
  assign wdata      = r_wdata;
  assign rd         = r_rd;
  assign wr         = r_wr;
  assign flush      = r_flush;

endmodule

`default_nettype wire

// File: tb/tb_cache_access_sequencer.sv
// ============================================================================
// Module   : tb_cache_access_sequencer
// Purpose  : Directed, table-driven self-checking bench for the cache access
//            sequencer (single accesses, FIFO fill, flush, watchdog, reset).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cache_access_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic        flush_req, flush_done;
  logic        resp_valid, resp_wr, resp_err, err_sticky;
  logic [31:0] resp_rdata, addr, wdata;
  logic        rd, wr, flush, stall;
  logic [31:0] w_rdata, tb_rdata;
  logic        model_mode;

  // Simple cache model: returned data is a fixed function of the address.
  assign w_rdata = model_mode ? (addr ^ 32'h5A5A_0000) : tb_rdata;

  always #5 clock = ~clock;

  cache_access_sequencer #(
    .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .FIFO_DEPTH(4),
    .FIFO_PTR_BITS(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .err_sticky(err_sticky),
    .addr(addr), .wdata(wdata), .rd(rd), .wr(wr), .flush(flush),
    .stall(stall), .rdata(w_rdata)
  );

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdv;
    int          stalls;
    logic        exp_resp_wr;
    logic [31:0] exp_rdata;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] q_rdata[$];
  vec_t        vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (resp_valid === 1'b1) q_rdata.push_back(resp_rdata);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string s;
    s = $sformatf("v%0d", idx);
    tb_rdata  = v.rdv;
    stall     = 1'b0;
    req_valid = 1'b1;
    req_wr    = v.wr;
    req_addr  = v.a;
    req_wdata = v.wd;
    check({s, "_ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check({s, "_rd_after_push"}, {31'd0, rd}, 32'd0);
    tick();
    check({s, "_rd_on"}, {31'd0, rd}, {31'd0, ~v.wr});
    check({s, "_wr_on"}, {31'd0, wr}, {31'd0, v.wr});
    check({s, "_addr"}, addr, v.a);
    if (v.wr) check({s, "_wdata"}, wdata, v.wd);
    for (int i = 0; i < v.stalls; i++) begin
      stall = 1'b1;
      tick();
      check({s, "_hold_rdwr"}, {30'd0, rd, wr}, {30'd0, ~v.wr, v.wr});
      check({s, "_hold_addr"}, addr, v.a);
      check({s, "_no_resp"}, {31'd0, resp_valid}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check({s, "_done_rdwr"}, {30'd0, rd, wr}, 32'd0);
    check({s, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({s, "_resp_wr"}, {31'd0, resp_wr}, {31'd0, v.exp_resp_wr});
    check({s, "_resp_rdata"}, resp_rdata, v.exp_rdata);
    check({s, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    tick();
    check({s, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    vecs[0] = '{1'b0, 32'h0000_0004, 32'h0,          32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'hAAAA_5555, 6, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          32'h0000_0001, 3, 1'b0, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1111_1111, 0, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0100, 32'h0,          32'hCAFE_F00D, 7, 1'b0, 32'hCAFE_F00D};

    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    flush_req = 1'b0; stall = 1'b0; tb_rdata = '0; model_mode = 1'b0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_ctrl", {27'd0, rd, wr, flush, resp_valid, flush_done}, 32'd0);
    check("rst_err", {30'd0, err_sticky, resp_err}, 32'd0);
    check("rst_addr", addr, 32'd0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
    check("no_err_yet", {31'd0, err_sticky}, 32'd0);

    // FIFO fill with stall held: 4 pushes, 5th waits for first completion.
    q_rdata.delete();
    model_mode = 1'b1;
    stall      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h1000 + 32'(4 * i);
      check($sformatf("fill_ready%0d", i), {31'd0, req_ready}, 32'd1);
      tick();
    end
    req_addr = 32'h1010;
    check("fill_full", {31'd0, req_ready}, 32'd0);
    tick();
    check("fill_full_e4", {31'd0, req_ready}, 32'd0);
    tick();
    check("fill_full_e5", {31'd0, req_ready}, 32'd0);
    check("fill_no_resp", 32'(q_rdata.size()), 32'd0);
    stall = 1'b0;
    tick();
    check("fill_first_resp", 32'(q_rdata.size()), 32'd1);
    check("fill_ready_again", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("fill_full_again", {31'd0, req_ready}, 32'd0);
    k = 0;
    while (q_rdata.size() < 5 && k < 30) begin
      tick();
      k++;
    end
    check("fill_resp_count", 32'(q_rdata.size()), 32'd5);
    for (int i = 0; i < 5 && i < q_rdata.size(); i++)
      check($sformatf("fill_order%0d", i), q_rdata[i], (32'h1000 + 32'(4 * i)) ^ 32'h5A5A_0000);

    // Flush ordered behind two loads.
    q_rdata.delete();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h2000;
    tick();
    req_addr = 32'h2004;
    tick();
    check("fl_rd_a", {31'd0, rd}, 32'd1);
    req_valid = 1'b0; flush_req = 1'b1;
    tick();
    check("fl_ready_low", {31'd0, req_ready}, 32'd0);
    check("fl_resp_a", resp_rdata, 32'h5A5A_2000);
    check("fl_no_flush_a", {31'd0, flush}, 32'd0);
    tick();
    flush_req = 1'b0;
    check("fl_rd_b", {31'd0, rd}, 32'd1);
    check("fl_addr_b", addr, 32'h2004);
    check("fl_no_flush_b", {31'd0, flush}, 32'd0);
    tick();
    check("fl_resp_b", {31'd0, resp_valid}, 32'd1);
    check("fl_resp_b_data", resp_rdata, 32'h5A5A_2004);
    check("fl_gap", {29'd0, rd, wr, flush}, 32'd0);
    tick();
    check("fl_flush_on", {29'd0, rd, wr, flush}, 32'd1);
    check("fl_ready_low2", {31'd0, req_ready}, 32'd0);
    check("fl_done_early", {31'd0, flush_done}, 32'd0);
    tick();
    check("fl_flush_off", {31'd0, flush}, 32'd0);
    check("fl_done", {31'd0, flush_done}, 32'd1);
    check("fl_ready_back", {31'd0, req_ready}, 32'd1);
    tick();
    check("fl_done_pulse", {31'd0, flush_done}, 32'd0);
    tick();
    check("fl_merged", {31'd0, flush}, 32'd0);
    check("fl_resp_count", 32'(q_rdata.size()), 32'd2);

    // Watchdog: stall stuck high.
    model_mode = 1'b0; tb_rdata = 32'h7777_7777; stall = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0300;
    tick();
    req_valid = 1'b0;
    tick();
    check("wd_rd_on", {31'd0, rd}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("wd_hold%0d", i), {30'd0, rd, resp_valid}, 32'd2);
    end
    tick();
    check("wd_rd_off", {31'd0, rd}, 32'd0);
    check("wd_resp", {29'd0, resp_valid, resp_err, err_sticky}, 32'd7);
    check("wd_rdata", resp_rdata, 32'd0);
    stall = 1'b0;
    tick(); tick();
    check("wd_sticky", {29'd0, err_sticky, resp_valid, rd}, 32'd4);

    // Reset in the middle of a miss with entries queued.
    stall = 1'b1; model_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h4000 + 32'(4 * i);
      tick();
    end
    req_valid = 1'b0;
    check("rm_rd_on", {31'd0, rd}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rm_async_ctrl", {28'd0, rd, wr, flush, resp_valid}, 32'd0);
    check("rm_ready", {31'd0, req_ready}, 32'd1);
    check("rm_sticky_clr", {31'd0, err_sticky}, 32'd0);
    @(negedge clock);
    reset = 1'b0; stall = 1'b0;
    q_rdata.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rm_idle%0d", i), {30'd0, rd, wr}, 32'd0);
    end
    check("rm_no_resp", 32'(q_rdata.size()), 32'd0);
    check("rm_ready_after", {31'd0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
